// File: rtl/gpio_host.sv
// Host-side controller for the GPIO peripheral: config/command port, output-data and sample streams,
// round-robin interrupt acknowledge with an event queue. Optional macro: GPIO_HOST_IRQ_DROP_EN.
module gpio_host #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_addr,
    input  logic [23:0]                      cmd_data,
    output logic [23:0]                      conf_0,
    output logic [16:0]                      conf_1,
    output logic                             gpio_din_valid,
    input  logic                             gpio_din_ready,
    output logic [WIDTH-1:0]                 gpio_din,
    input  logic                             gpio_dout_valid,
    output logic                             gpio_dout_ready,
    input  logic [WIDTH-1:0]                 gpio_dout,
    input  logic [WIDTH:0]                   ir_valid,
    output logic [WIDTH:0]                   ir_ready,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [$clog2(WIDTH+1)+WIDTH-1:0] evt_data,
    output logic                             evt_overflow
);
    // Every stream here moves a word only on the edge where valid and ready are both high.
    localparam int IDXW = $clog2(WIDTH + 1);
    localparam int EVTW = IDXW + WIDTH;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [IDXW:0]    NPORT    = (IDXW + 1)'(WIDTH + 1);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(WIDTH);
    localparam logic [WIDTH:0]   ONE_HOT0 = (WIDTH + 1)'(1);

    typedef enum logic {CIDLE, CDOUT} cmd_state_t;
    typedef enum logic {ISCAN, IHOLD} irq_state_t;

    cmd_state_t cmd_state, cmd_next;
    irq_state_t irq_state, irq_next;

    logic            cmd_fire, din_fire, dout_fire, flush;
    logic [WIDTH-1:0] last_sample;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign din_fire  = gpio_din_valid & gpio_din_ready;
    assign dout_fire = gpio_dout_valid & gpio_dout_ready;
    assign flush     = cmd_fire && (cmd_addr == 2'd3);

    always_comb begin
        cmd_next = cmd_state;
        case (cmd_state)
            CIDLE:   if (cmd_fire && cmd_addr == 2'd2) cmd_next = CDOUT;
            CDOUT:   if (din_fire) cmd_next = CIDLE;
            default: cmd_next = CIDLE;
        endcase
    end

    // cmd_ready is registered from the next state so it drops on the same edge that enters CDOUT.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_state      <= CIDLE;
            cmd_ready      <= 1'b0;
            conf_0         <= '0;
            conf_1         <= '0;
            gpio_din       <= '0;
            gpio_din_valid <= 1'b0;
        end else begin
            cmd_state <= cmd_next;
            cmd_ready <= (cmd_next == CIDLE);
            if (din_fire) gpio_din_valid <= 1'b0;
            if (cmd_fire) begin
                case (cmd_addr)
                    2'd0: conf_0 <= cmd_data;
                    2'd1: conf_1 <= cmd_data[16:0];
                    2'd2: begin
                        gpio_din       <= cmd_data[WIDTH-1:0];
                        gpio_din_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gpio_dout_ready <= 1'b0;
            last_sample     <= '0;
        end else begin
            gpio_dout_ready <= 1'b1;
            if (dout_fire) last_sample <= gpio_dout;
        end
    end

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit.
    logic [IDXW-1:0]    irq_ptr, sel_off, sel_idx, ptr_next;
    logic [2*WIDTH+1:0] req_dbl;
    logic [WIDTH:0]     req_rot;
    logic [IDXW:0]      sel_sum;
    logic               sel_found, ack_ok, irq_fire;
    logic               fifo_full, push_en, pop;
    logic [CNTW-1:0]    fifo_cnt;

    always_comb begin
        req_dbl   = {ir_valid, ir_valid} >> irq_ptr;
        req_rot   = req_dbl[WIDTH:0];
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = WIDTH; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_found = 1'b1;
                sel_off   = IDXW'(i);
            end
        end
        sel_sum  = {1'b0, irq_ptr} + {1'b0, sel_off};
        sel_idx  = (sel_sum >= NPORT) ? IDXW'(sel_sum - NPORT) : sel_sum[IDXW-1:0];
        ptr_next = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDXW'(1);
    end

`ifdef GPIO_HOST_IRQ_DROP_EN
    assign ack_ok = 1'b1;
`else
    assign ack_ok = ~fifo_full;
`endif

    assign irq_fire = (irq_state == ISCAN) && sel_found && ack_ok;

    always_comb begin
        irq_next = irq_state;
        case (irq_state)
            ISCAN:   if (irq_fire) irq_next = IHOLD;
            IHOLD:   irq_next = ISCAN;
            default: irq_next = ISCAN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_state <= ISCAN;
            ir_ready  <= '0;
            irq_ptr   <= '0;
        end else begin
            irq_state <= irq_next;
            ir_ready  <= irq_fire ? (ONE_HOT0 << sel_idx) : '0;
            if (irq_fire) irq_ptr <= ptr_next;
        end
    end

    // Event queue, first-word-fall-through; push is gated on the pre-edge full flag.
    logic [EVTW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;

    assign fifo_full = (fifo_cnt == CNTW'(FIFO_DEPTH));
    assign evt_valid = (fifo_cnt != '0);
    assign evt_data  = fifo_mem[rd_ptr];
    assign push_en   = irq_fire & ~fifo_full;
    assign pop       = evt_valid & evt_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)     rd_ptr <= rd_ptr + PTRW'(1);
            fifo_cnt <= fifo_cnt + CNTW'(push_en) - CNTW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && push_en) fifo_mem[wr_ptr] <= {sel_idx, last_sample};
    end

`ifdef GPIO_HOST_IRQ_DROP_EN
    always_ff @(posedge clock) begin
        if (reset || flush)          evt_overflow <= 1'b0;
        else if (irq_fire && fifo_full) evt_overflow <= 1'b1;
    end
`else
    assign evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_host.sv
// Directed bench for gpio_host with queue-based scoreboards for acks, events and output data.
// Expectations follow GPIO_HOST_IRQ_DROP_EN when the bench is built with it defined.
module tb_gpio_host;
    localparam int WIDTH = 8;
    localparam int EVTW  = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_addr = '0;
    logic [23:0]      cmd_data = '0;
    logic [23:0]      conf_0;
    logic [16:0]      conf_1;
    logic             gpio_din_valid;
    logic             gpio_din_ready = 1'b0;
    logic [WIDTH-1:0] gpio_din;
    logic             gpio_dout_valid = 1'b0;
    logic             gpio_dout_ready;
    logic [WIDTH-1:0] gpio_dout = '0;
    logic [WIDTH:0]   ir_valid = '0;
    logic [WIDTH:0]   ir_ready;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [EVTW-1:0]  evt_data;
    logic             evt_overflow;

    int checks = 0;
    int errors = 0;
    logic auto_clear = 1'b0;
    logic prev_ack = 1'b0;

    logic [EVTW-1:0]  exp_q[$];
    logic [WIDTH:0]   ack_q[$];
    logic [WIDTH-1:0] din_q[$];

    gpio_host #(.WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .conf_0(conf_0), .conf_1(conf_1),
        .gpio_din_valid(gpio_din_valid), .gpio_din_ready(gpio_din_ready), .gpio_din(gpio_din),
        .gpio_dout_valid(gpio_dout_valid), .gpio_dout_ready(gpio_dout_ready), .gpio_dout(gpio_dout),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .evt_overflow(evt_overflow)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle; the GPIO model drops each interrupt request once it sees its acknowledge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_clear) ir_valid = ir_valid & ~ir_ready;
    endtask

    task automatic cmd_write(input logic [1:0] a, input logic [23:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Monitors
    always @(negedge clock) begin
        if (ir_ready != '0) begin
            check("ack_pulse_width", 32'(prev_ack), 32'd0);
            if (ack_q.size() == 0) check("ack_unexpected", 32'(ir_ready), 32'd0);
            else check("ack_order", 32'(ir_ready), 32'(ack_q.pop_front()));
        end
        prev_ack = (ir_ready != '0);
    end

    always @(negedge clock) begin
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) check("evt_unexpected", 32'(evt_data), 32'hFFFF_FFFF);
            else check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (gpio_din_valid && gpio_din_ready) begin
            if (din_q.size() == 0) check("din_unexpected", 32'(gpio_din), 32'hFFFF_FFFF);
            else check("din_data", 32'(gpio_din), 32'(din_q.pop_front()));
        end
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_conf_0", 32'(conf_0), 32'd0);
        check("rst_conf_1", 32'(conf_1), 32'd0);
        check("rst_din_valid", 32'(gpio_din_valid), 32'd0);
        check("rst_din", 32'(gpio_din), 32'd0);
        check("rst_dout_ready", 32'(gpio_dout_ready), 32'd0);
        check("rst_ir_ready", 32'(ir_ready), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_overflow", 32'(evt_overflow), 32'd0);
        reset = 1'b0;
        tick();
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        check("dout_ready_after_reset", 32'(gpio_dout_ready), 32'd1);

        // Configuration writes
        cmd_write(2'd0, 24'h01FF00);
        check("conf_0_write", 32'(conf_0), 32'h01FF00);
        cmd_write(2'd1, 24'h000001);
        check("conf_1_write", 32'(conf_1), 32'h1);

        // Output data with a stalled GPIO
        din_q.push_back(8'hA5);
        cmd_write(2'd2, 24'h0000A5);
        check("din_value", 32'(gpio_din), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            check("din_valid_held", 32'(gpio_din_valid), 32'd1);
            check("cmd_ready_in_cdout", 32'(cmd_ready), 32'd0);
            tick();
        end
        check("din_valid_cycle6", 32'(gpio_din_valid), 32'd1);
        gpio_din_ready = 1'b1;
        tick();
        gpio_din_ready = 1'b0;
        check("din_valid_dropped", 32'(gpio_din_valid), 32'd0);
        check("cmd_ready_after_din", 32'(cmd_ready), 32'd1);

        // Three simultaneous interrupts from pointer 0; sample register still 0
        auto_clear = 1'b1;
        evt_ready  = 1'b1;
        ack_q.push_back(9'h001); ack_q.push_back(9'h020); ack_q.push_back(9'h100);
        exp_q.push_back({4'd0, 8'h00}); exp_q.push_back({4'd5, 8'h00}); exp_q.push_back({4'd8, 8'h00});
        ir_valid = 9'h121;
        n = 0;
        while (ir_valid != '0 && n < 30) begin
            tick();
            n++;
        end
        check("rr_ack_span", 32'(n), 32'd5);
        repeat (3) tick();

        // Single interrupt carries the captured sample; pointer wrapped to 0
        gpio_dout       = 8'h3C;
        gpio_dout_valid = 1'b1;
        tick();
        gpio_dout_valid = 1'b0;
        evt_ready = 1'b0;
        ack_q.push_back(9'h004);
        exp_q.push_back({4'd2, 8'h3C});
        ir_valid = 9'h004;
        tick();
        check("irq2_evt_valid", 32'(evt_valid), 32'd1);
        check("irq2_evt_data", 32'(evt_data), 32'h23C);
        tick();
        check("irq2_ready_low", 32'(ir_ready), 32'd0);
        evt_ready = 1'b1;
        tick();

        // Pointer is 3: bits 1 and 3 are served 3 first, then 1 after wrapping
        ack_q.push_back(9'h008); ack_q.push_back(9'h002);
        exp_q.push_back({4'd3, 8'h3C}); exp_q.push_back({4'd1, 8'h3C});
        ir_valid = 9'h00A;
        n = 0;
        while (ir_valid != '0 && n < 30) begin
            tick();
            n++;
        end
        check("wrap_ack_span", 32'(n), 32'd3);
        repeat (3) tick();

        // Six interrupts into a 4-deep queue with no consumer; pointer is 2
        evt_ready = 1'b0;
        ack_q.push_back(9'h004); ack_q.push_back(9'h008); ack_q.push_back(9'h010);
        ack_q.push_back(9'h020); ack_q.push_back(9'h001); ack_q.push_back(9'h002);
        ir_valid = 9'h03F;
        repeat (14) tick();
        check("full_head_valid", 32'(evt_valid), 32'd1);
        check("full_head_data", 32'(evt_data), 32'h23C);
`ifdef GPIO_HOST_IRQ_DROP_EN
        check("drop_all_acked", 32'(ir_valid), 32'd0);
        check("drop_overflow_set", 32'(evt_overflow), 32'd1);
        cmd_write(2'd3, 24'd0);
        check("drop_flush_empty", 32'(evt_valid), 32'd0);
        check("drop_flush_overflow", 32'(evt_overflow), 32'd0);
`else
        check("bp_pending", 32'(ir_valid), 32'h003);
        check("bp_overflow", 32'(evt_overflow), 32'd0);
        exp_q.push_back({4'd2, 8'h3C}); exp_q.push_back({4'd3, 8'h3C});
        exp_q.push_back({4'd4, 8'h3C}); exp_q.push_back({4'd5, 8'h3C});
        exp_q.push_back({4'd0, 8'h3C}); exp_q.push_back({4'd1, 8'h3C});
        evt_ready = 1'b1;
        n = 0;
        while ((ir_valid != '0 || evt_valid) && n < 60) begin
            tick();
            n++;
        end
        check("bp_drained_irq", 32'(ir_valid), 32'd0);
        check("bp_drained_evt", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
`endif

        // Flush discards a queued event
        ack_q.push_back(9'h040);
        ir_valid = 9'h040;
        n = 0;
        while (ir_valid != '0 && n < 30) begin
            tick();
            n++;
        end
        check("flush_pre_valid", 32'(evt_valid), 32'd1);
        check("flush_pre_data", 32'(evt_data), 32'h63C);
        cmd_write(2'd3, 24'd0);
        check("flush_empty", 32'(evt_valid), 32'd0);
        check("flush_overflow", 32'(evt_overflow), 32'd0);

        // Reset while in CDOUT and IHOLD, with another request pending
        cmd_write(2'd2, 24'h00005A);
        check("cdout_entered", 32'(gpio_din_valid), 32'd1);
        ack_q.push_back(9'h010);
        ir_valid = 9'h010;
        tick();
        check("ihold_ack", 32'(ir_ready), 32'h010);
        reset      = 1'b1;
        auto_clear = 1'b0;
        ir_valid   = 9'h080;
        tick();
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_din_valid", 32'(gpio_din_valid), 32'd0);
        check("mid_rst_din", 32'(gpio_din), 32'd0);
        check("mid_rst_ir_ready", 32'(ir_ready), 32'd0);
        check("mid_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_conf_0", 32'(conf_0), 32'd0);
        check("mid_rst_dout_ready", 32'(gpio_dout_ready), 32'd0);
        tick();
        check("rst_no_push", 32'(evt_valid), 32'd0);
        check("rst_no_ack", 32'(ir_ready), 32'd0);
        ir_valid = '0;
        reset    = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("post_rst_din_valid", 32'(gpio_din_valid), 32'd0);
        repeat (2) tick();

        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("din_q_drained", 32'(din_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
